// File: rtl/fir_da_pkg.sv
// Shared definitions for the distributed-arithmetic FIR engine.
//   clog2   : ceiling log2 for parameter sizing
//   lut_w   : width of one partial-sum LUT entry (COEF_W + clog2(TAPS))
//   acc_w   : full-precision accumulator/result width
//   cnt_w   : bit-position counter width (at least 1 bit)
//   state_t : engine FSM states
package fir_da_pkg;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int lut_w(input int taps, input int coef_w);
    return coef_w + clog2(taps);
  endfunction

  function automatic int acc_w(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + clog2(taps);
  endfunction

  function automatic int cnt_w(input int data_w);
    return (clog2(data_w) < 1) ? 1 : clog2(data_w);
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/da_lut.sv
// Combinational partial-sum LUT for the DA FIR engine.
// Entry a is the sum of every coefficient h_k whose bit k of a is set,
// sign-extended to LUT_W; entry 0 is zero.
//   addr  : one bit per tap (current bit of each sample)
//   value : signed partial sum
module da_lut
  import fir_da_pkg::*;
#(
  parameter int                      TAPS   = 4,
  parameter int                      COEF_W = 8,
  parameter logic [TAPS*COEF_W-1:0]  COEFS  = 32'h04030201,
  localparam int                     LUT_W  = lut_w(TAPS, COEF_W)
) (
  input  logic [TAPS-1:0]         addr,
  output logic signed [LUT_W-1:0] value
);

  always_comb begin
    value = '0;
    for (int unsigned k = 0; k < TAPS; k++) begin
      if (addr[k]) begin
        value = value + LUT_W'(signed'(COEFS[k*COEF_W +: COEF_W]));
      end
    end
  end

endmodule

// File: rtl/da_fir_engine.sv
// Bit-serial distributed-arithmetic FIR engine.
// Latches a parallel tap vector, then walks the sample bits LSB first,
// adding the shifted LUT partial sum each cycle and subtracting it on the
// sign bit. One result every DATA_W+1 clocks with a one-cycle valid pulse.
//   clk, resetn : clock, synchronous active-low reset
//   clear       : synchronous soft clear (abandons any run, keeps y_out)
//   start       : level-sensitive run request, sampled in IDLE only
//   taps_in     : slice k holds x[n-k]
//   y_out       : signed full-precision result
//   y_valid     : one-cycle pulse when y_out is updated
//   busy        : high while the engine is running
module da_fir_engine
  import fir_da_pkg::*;
#(
  parameter int                      TAPS   = 4,
  parameter int                      DATA_W = 8,
  parameter int                      COEF_W = 8,
  parameter logic [TAPS*COEF_W-1:0]  COEFS  = 32'h04030201,
  localparam int                     ACC_W  = acc_w(DATA_W, COEF_W, TAPS)
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       clear,
  input  logic                       start,
  input  logic [TAPS*DATA_W-1:0]     taps_in,
  output logic signed [ACC_W-1:0]    y_out,
  output logic                       y_valid,
  output logic                       busy
);

  localparam int LUT_W = lut_w(TAPS, COEF_W);
  localparam int CNT_W = cnt_w(DATA_W);

  state_t                          state_q, state_d;
  logic [TAPS-1:0][DATA_W-1:0]     sr_q, sr_d;
  logic signed [ACC_W-1:0]         acc_q, acc_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic signed [ACC_W-1:0]         y_out_q, y_out_d;
  logic                            y_valid_q, y_valid_d;

  logic [TAPS-1:0]                 addr;
  logic signed [LUT_W-1:0]         lut_val;
  logic signed [ACC_W-1:0]         term;
  logic signed [ACC_W-1:0]         acc_sum;
  logic                            last_bit;

  always_comb begin
    addr = '0;
    for (int unsigned k = 0; k < TAPS; k++) begin
      addr[k] = sr_q[k][0];
    end
  end

  da_lut #(
    .TAPS   (TAPS),
    .COEF_W (COEF_W),
    .COEFS  (COEFS)
  ) u_lut (
    .addr  (addr),
    .value (lut_val)
  );

  // The sign bit of a two's-complement sample carries negative weight.
  assign last_bit = (cnt_q == CNT_W'(DATA_W - 1));
  assign term     = ACC_W'(lut_val) <<< cnt_q;
  assign acc_sum  = last_bit ? (acc_q - term) : (acc_q + term);

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    y_out_d   = y_out_q;
    y_valid_d = 1'b0;
    if (clear) begin
      state_d = IDLE;
      sr_d    = '0;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            sr_d    = taps_in;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          acc_d = acc_sum;
          cnt_d = cnt_q + CNT_W'(1);
          for (int unsigned k = 0; k < TAPS; k++) begin
            sr_d[k] = sr_q[k] >> 1;
          end
          if (last_bit) begin
            y_out_d   = acc_sum;
            y_valid_d = 1'b1;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      y_out_q   <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      y_out_q   <= y_out_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign y_out   = y_out_q;
  assign y_valid = y_valid_q;
  assign busy    = (state_q == RUN);

endmodule

// File: tb/tb_da_fir_engine.sv
// Directed bench for da_fir_engine: default coefficients (1,2,3,4) and a
// second instance with every coefficient at -128, both fed the same controls.
module tb_da_fir_engine;

  logic               clk;
  logic               resetn;
  logic               clear;
  logic               start;
  logic [31:0]        taps_in;
  logic signed [17:0] y_out, y_out_x;
  logic               y_valid, y_valid_x;
  logic               busy, busy_x;

  int nvec;
  int nmis;

  da_fir_engine #(
    .TAPS   (4),
    .DATA_W (8),
    .COEF_W (8),
    .COEFS  (32'h04030201)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (clear),
    .start   (start),
    .taps_in (taps_in),
    .y_out   (y_out),
    .y_valid (y_valid),
    .busy    (busy)
  );

  da_fir_engine #(
    .TAPS   (4),
    .DATA_W (8),
    .COEF_W (8),
    .COEFS  (32'h80808080)
  ) dut_x (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (clear),
    .start   (start),
    .taps_in (taps_in),
    .y_out   (y_out_x),
    .y_valid (y_valid_x),
    .busy    (busy_x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Single start pulse; expects 8 busy cycles, then the valid pulse.
  task automatic run_one(input logic signed [7:0] x0, input logic signed [7:0] x1,
                         input logic signed [7:0] x2, input logic signed [7:0] x3,
                         input int exp_y, input int exp_x, input string tag);
    int busy_cnt;
    int n;
    @(negedge clk);
    taps_in = {x3, x2, x1, x0};
    start   = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    busy_cnt = 0;
    n        = 0;
    while (!y_valid && n < 30) begin
      if (busy) busy_cnt++;
      n++;
      @(negedge clk);
    end
    check({tag, "_valid"}, int'(y_valid), 1);
    check({tag, "_busy_cycles"}, busy_cnt, 8);
    check({tag, "_busy_at_valid"}, int'(busy), 0);
    check({tag, "_y"}, int'(y_out), exp_y);
    check({tag, "_y_x"}, int'(y_out_x), exp_x);
    @(negedge clk);
    check({tag, "_valid_drop"}, int'(y_valid), 0);
  endtask

  initial begin
    logic signed [7:0] v [4];
    int exp_y;
    int exp_x;
    int bad;
    int nv;

    nvec    = 0;
    nmis    = 0;
    resetn  = 1'b0;
    clear   = 1'b0;
    start   = 1'b1;
    taps_in = $urandom;

    // Reset held with start high and random taps.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_y", int'(y_out), 0);
      check("rst_valid", int'(y_valid), 0);
      check("rst_busy", int'(busy), 0);
      taps_in = $urandom;
    end

    // Release with start still high: first load on the first edge with resetn=1.
    taps_in = 32'h01010101;
    resetn  = 1'b1;
    @(negedge clk);
    check("rel_busy", int'(busy), 1);
    start = 1'b0;
    nv = 0;
    for (int i = 0; i < 20 && !y_valid; i++) @(negedge clk);
    check("rel_valid", int'(y_valid), 1);
    check("rel_y", int'(y_out), 10);
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (y_valid) nv++;
    end
    check("no_extra_valid", nv, 0);

    run_one(8'sd1, 8'sd1, 8'sd1, 8'sd1, 10, -512, "unit");
    run_one(-8'sd128, 8'sd0, 8'sd0, 8'sd0, -128, 16384, "minx0");
    run_one(-8'sd1, -8'sd1, -8'sd1, -8'sd1, -10, 512, "neg1");
    run_one(8'sd5, -8'sd3, 8'sd7, -8'sd2, 12, -896, "mixed");
    run_one(-8'sd128, -8'sd128, -8'sd128, -8'sd128, -1280, 65536, "all_min");
    run_one(8'sd127, 8'sd127, 8'sd127, 8'sd127, 1270, -65024, "all_max");

    // Back-to-back with start held high; new taps presented at each load edge.
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 4; i++) v[i] = 8'($urandom);
    taps_in = {v[3], v[2], v[1], v[0]};
    for (int t = 0; t < 100; t++) begin
      exp_y = int'(v[0]) + 2 * int'(v[1]) + 3 * int'(v[2]) + 4 * int'(v[3]);
      exp_x = -128 * (int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]));
      bad = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (y_valid || !busy) bad++;
      end
      @(negedge clk);
      check("b2b_gap", bad, 0);
      check("b2b_valid", int'(y_valid), 1);
      check("b2b_y", int'(y_out), exp_y);
      check("b2b_y_x", int'(y_out_x), exp_x);
      for (int i = 0; i < 4; i++) v[i] = 8'($urandom);
      taps_in = {v[3], v[2], v[1], v[0]};
      if (t == 99) start = 1'b0;
    end

    // Establish a known held result before the abandoned run.
    run_one(8'sd1, 8'sd1, 8'sd1, 8'sd1, 10, -512, "pre_clr");

    @(negedge clk);
    taps_in = {-8'sd2, 8'sd7, -8'sd3, 8'sd5};
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("clr_busy_before", int'(busy), 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_busy_after", int'(busy), 0);
    nv = 0;
    for (int i = 0; i < 15; i++) begin
      if (y_valid) nv++;
      @(negedge clk);
    end
    check("clr_no_valid", nv, 0);
    check("clr_y_hold", int'(y_out), 10);

    // Clear wins over start in the same IDLE cycle.
    clear = 1'b1;
    start = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    start = 1'b0;
    check("clr_prio_busy", int'(busy), 0);

    run_one(8'sd5, -8'sd3, 8'sd7, -8'sd2, 12, -896, "post_clr");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
